// File: rtl/uart_echo_buffer_if.sv
// uart_echo_buffer_if
//   Handshake bundle between simple_uart and uart_echo_buffer.
//
//   Signals
//     rx_value        word received by the UART
//     rx_value_ready  1-cycle strobe, rx_value valid
//     tx_value        word to transmit, held stable until tx_value_done
//     tx_value_write  1-cycle strobe launching a transmission
//     tx_value_done   1-cycle strobe, transmission finished
//
//   Modports
//     master  echo buffer side (consumes rx, drives tx)
//     slave   UART side (drives rx and done, consumes tx)
interface uart_echo_buffer_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] rx_value;
  logic                  rx_value_ready;
  logic [DATA_WIDTH-1:0] tx_value;
  logic                  tx_value_write;
  logic                  tx_value_done;

  modport master (
    input  rx_value,
    input  rx_value_ready,
    input  tx_value_done,
    output tx_value,
    output tx_value_write
  );

  modport slave (
    output rx_value,
    output rx_value_ready,
    output tx_value_done,
    input  tx_value,
    input  tx_value_write
  );

endinterface

// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer
//   Buffered UART echo engine. Received words are absorbed into a FIFO and
//   replayed one at a time towards the UART transmitter; the next word is
//   only launched after the UART reports the previous one as done.
//   Fill level, overflow statistics and the last echoed word are exported
//   for LEDs and debug.
//
//   Optional feature macro: UART_ECHO_CRLF_EN
//     When defined, every echoed carriage return (8'h0D) is followed by a
//     generated line feed (8'h0A) that does not consume a FIFO entry.
//     When undefined, 8'h0D is echoed like any other word.
//
//   Parameters
//     DATA_WIDTH       UART word width (>= 8 when UART_ECHO_CRLF_EN is defined)
//     LOG2_DEPTH       FIFO depth is 2**LOG2_DEPTH words
//     OVF_COUNT_WIDTH  width of the saturating overflow counter
//
//   Ports
//     clock       in   system clock
//     arst_n      in   asynchronous active-low reset
//     uart        if   master side of uart_echo_buffer_if (rx in, tx out)
//     last_value  out  last word issued on tx_value
//     level       out  FIFO occupancy, 0..2**LOG2_DEPTH
//     empty       out  registered FIFO empty flag
//     full        out  registered FIFO full flag
//     ovf_count   out  number of dropped words, saturates at all-ones
module uart_echo_buffer #(
  parameter int DATA_WIDTH      = 8,
  parameter int LOG2_DEPTH      = 4,
  parameter int OVF_COUNT_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       arst_n,
  uart_echo_buffer_if.master         uart,
  output logic [DATA_WIDTH-1:0]      last_value,
  output logic [LOG2_DEPTH:0]        level,
  output logic                       empty,
  output logic                       full,
  output logic [OVF_COUNT_WIDTH-1:0] ovf_count
);

  localparam int DEPTH = 2 ** LOG2_DEPTH;

  localparam logic [LOG2_DEPTH:0]        LEVEL_FULL = (LOG2_DEPTH + 1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0]        LEVEL_ONE  = (LOG2_DEPTH + 1)'(1);
  localparam logic [LOG2_DEPTH-1:0]      PTR_ONE    = LOG2_DEPTH'(1);
  localparam logic [OVF_COUNT_WIDTH-1:0] OVF_ONE    = OVF_COUNT_WIDTH'(1);
  localparam logic [OVF_COUNT_WIDTH-1:0] OVF_MAX    = '1;

`ifdef UART_ECHO_CRLF_EN
  localparam logic [DATA_WIDTH-1:0] CR_WORD = DATA_WIDTH'(8'h0D);
  localparam logic [DATA_WIDTH-1:0] LF_WORD = DATA_WIDTH'(8'h0A);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_LF      = 2'd2,
    ST_LF_WAIT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1
  } state_t;
`endif

  state_t state;
  state_t state_next;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;
  logic [LOG2_DEPTH:0]   level_next;
  logic [DATA_WIDTH-1:0] head;

  logic fifo_pop;
  logic push_ok;
  logic push_drop;

`ifdef UART_ECHO_CRLF_EN
  logic load_lf;
`endif

  // Transmit-side registers
  logic [DATA_WIDTH-1:0] tx_value_q;
  logic                  tx_write_q;

  assign uart.tx_value       = tx_value_q;
  assign uart.tx_value_write = tx_write_q;

  assign head = mem[rd_ptr];

  // A word arriving while the FIFO is full still fits if the head leaves
  // in the same cycle; rx is never back-pressured, so anything else is lost.
  assign push_ok   = uart.rx_value_ready && (!full || fifo_pop);
  assign push_drop = uart.rx_value_ready && !push_ok;

  // State register
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
`ifdef UART_ECHO_CRLF_EN
    load_lf    = 1'b0;
`endif

    case (state)
      ST_IDLE: begin
        if (!empty) begin
          fifo_pop   = 1'b1;
          state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (uart.tx_value_done) begin
`ifdef UART_ECHO_CRLF_EN
          // tx_value still holds the word that just completed
          if (tx_value_q == CR_WORD) begin
            state_next = ST_LF;
          end else begin
            state_next = ST_IDLE;
          end
`else
          state_next = ST_IDLE;
`endif
        end
      end

`ifdef UART_ECHO_CRLF_EN
      ST_LF: begin
        load_lf    = 1'b1;
        state_next = ST_LF_WAIT;
      end

      ST_LF_WAIT: begin
        if (uart.tx_value_done) begin
          state_next = ST_IDLE;
        end
      end
`endif

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Transmit word, launch strobe and last-echoed word
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      tx_value_q <= '0;
      tx_write_q <= 1'b0;
      last_value <= '0;
    end else begin
      tx_write_q <= 1'b0;
      if (fifo_pop) begin
        tx_value_q <= head;
        last_value <= head;
        tx_write_q <= 1'b1;
      end
`ifdef UART_ECHO_CRLF_EN
      if (load_lf) begin
        tx_value_q <= LF_WORD;
        last_value <= LF_WORD;
        tx_write_q <= 1'b1;
      end
`endif
    end
  end

  // Occupancy after this cycle's push/pop
  always_comb begin
    level_next = level;
    if (push_ok && !fifo_pop) begin
      level_next = level + LEVEL_ONE;
    end else if (!push_ok && fifo_pop) begin
      level_next = level - LEVEL_ONE;
    end
  end

  // Pointers, level, flags and overflow counter; flags are derived from
  // level_next so they stay in step with the registered level.
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      ovf_count <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      level <= level_next;
      empty <= (level_next == '0);
      full  <= (level_next == LEVEL_FULL);
      if (push_drop && (ovf_count != OVF_MAX)) begin
        ovf_count <= ovf_count + OVF_ONE;
      end
    end
  end

  // Storage array has no reset; validity is tracked by the pointers.
  // When full, the write and the head read may hit the same slot in one
  // cycle: the head is read before the edge, the new word lands after it.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= uart.rx_value;
    end
  end

  // Internal consistency properties
  a_empty_consistent : assert property (
    @(posedge clock) disable iff (!arst_n) empty == (level == '0)
  );

  a_full_consistent : assert property (
    @(posedge clock) disable iff (!arst_n) full == (level == LEVEL_FULL)
  );

  a_write_single_pulse : assert property (
    @(posedge clock) disable iff (!arst_n) tx_write_q |=> !tx_write_q
  );

endmodule

// File: tb/tb_uart_echo_buffer.sv
// tb_uart_echo_buffer
//   Self-checking bench for uart_echo_buffer. Stimulus tasks push the words
//   expected on tx_value into a scoreboard queue; an independent monitor
//   pops and compares on every tx_value_write. Directed checks cover reset,
//   latency, full/overflow behaviour, CR/LF insertion and pointer wrap.
module tb_uart_echo_buffer;

  localparam int DATA_WIDTH      = 8;
  localparam int LOG2_DEPTH      = 4;
  localparam int OVF_COUNT_WIDTH = 8;

`ifdef UART_ECHO_CRLF_EN
  localparam int CRLF_WRITES = 3;
`else
  localparam int CRLF_WRITES = 2;
`endif

  logic                       clock = 1'b0;
  logic                       arst_n;
  logic [DATA_WIDTH-1:0]      last_value;
  logic [LOG2_DEPTH:0]        level;
  logic                       empty;
  logic                       full;
  logic [OVF_COUNT_WIDTH-1:0] ovf_count;

  int num_checks  = 0;
  int num_fail    = 0;
  int writes_seen = 0;

  logic [DATA_WIDTH-1:0] exp_q [$];

  uart_echo_buffer_if #(.DATA_WIDTH(DATA_WIDTH)) uart_bus ();

  uart_echo_buffer #(
    .DATA_WIDTH      (DATA_WIDTH),
    .LOG2_DEPTH      (LOG2_DEPTH),
    .OVF_COUNT_WIDTH (OVF_COUNT_WIDTH)
  ) dut (
    .clock      (clock),
    .arst_n     (arst_n),
    .uart       (uart_bus),
    .last_value (last_value),
    .level      (level),
    .empty      (empty),
    .full       (full),
    .ovf_count  (ovf_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One rx strobe; optionally records the echo(es) it should produce
  task automatic applyStimulus(input logic [DATA_WIDTH-1:0] word, input bit expect_echo);
    uart_bus.rx_value       = word;
    uart_bus.rx_value_ready = 1'b1;
    if (expect_echo) begin
      exp_q.push_back(word);
`ifdef UART_ECHO_CRLF_EN
      if (word == 8'h0D) begin
        exp_q.push_back(8'h0A);
      end
`endif
    end
    tick();
    uart_bus.rx_value_ready = 1'b0;
  endtask

  task automatic pulseDone();
    uart_bus.tx_value_done = 1'b1;
    tick();
    uart_bus.tx_value_done = 1'b0;
  endtask

  task automatic waitWrites(input int target);
    for (int i = 0; i < 40 && writes_seen < target; i++) begin
      tick();
    end
    checkOutput("write_arrival", writes_seen, target);
  endtask

  // Acknowledge writes until every expected word has been seen, then
  // release the final one so the engine returns to idle.
  task automatic drainAll();
    int guard;
    int w;
    guard = 0;
    while (exp_q.size() > 0 && guard < 64) begin
      w = writes_seen;
      pulseDone();
      waitWrites(w + 1);
      guard++;
    end
    checkOutput("queue_drained", exp_q.size(), 0);
    pulseDone();
    tick();
    tick();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_tx_value"},       uart_bus.tx_value,       0);
    checkOutput({tag, "_tx_value_write"}, uart_bus.tx_value_write, 0);
    checkOutput({tag, "_last_value"},     last_value,              0);
    checkOutput({tag, "_level"},          level,                   0);
    checkOutput({tag, "_empty"},          empty,                   1);
    checkOutput({tag, "_full"},           full,                    0);
    checkOutput({tag, "_ovf_count"},      ovf_count,               0);
  endtask

  // Scoreboard monitor: every launched word must match the next expectation
  always @(negedge clock) begin
    if (arst_n === 1'b1 && uart_bus.tx_value_write === 1'b1) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        num_checks++;
        num_fail++;
        $display("[TB] FAIL unexpected_write: got 0x%0h, expected no write at %0t",
                 uart_bus.tx_value, $time);
      end else begin
        logic [DATA_WIDTH-1:0] exp_word;
        exp_word = exp_q.pop_front();
        checkOutput("tx_value", uart_bus.tx_value, exp_word);
        checkOutput("last_value", last_value, exp_word);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int w0;

    arst_n                  = 1'b0;
    uart_bus.rx_value       = '0;
    uart_bus.rx_value_ready = 1'b0;
    uart_bus.tx_value_done  = 1'b0;
    repeat (3) tick();
    checkResetState("por");
    arst_n = 1'b1;
    tick();

    // Reset while a word is in flight, then a stray done
    $display("[TB] reset during transmission");
    w = writes_seen;
    applyStimulus(8'h55, 1'b1);
    waitWrites(w + 1);
    tick();
    #2 arst_n = 1'b0;
    #1 checkResetState("mid_wait");
    tick();
    arst_n = 1'b1;
    tick();
    w = writes_seen;
    pulseDone();
    repeat (5) tick();
    checkOutput("stray_done_no_write", writes_seen, w);
    checkOutput("stray_done_empty", empty, 1);

    // Single byte latency
    $display("[TB] single byte");
    applyStimulus(8'h41, 1'b1);
    checkOutput("single_empty_n1", empty, 0);
    checkOutput("single_level_n1", level, 1);
    checkOutput("single_write_n1", uart_bus.tx_value_write, 0);
    tick();
    checkOutput("single_write_n2", uart_bus.tx_value_write, 1);
    checkOutput("single_tx_n2", uart_bus.tx_value, 8'h41);
    checkOutput("single_last_n2", last_value, 8'h41);
    checkOutput("single_level_n2", level, 0);
    tick();
    checkOutput("single_write_n3", uart_bus.tx_value_write, 0);
    pulseDone();
    tick();
    tick();

    // Burst: first word goes straight to tx, the next 16 fill the FIFO
    $display("[TB] burst and overflow");
    w = writes_seen;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(8'(i), 1'b1);
    end
    tick();
    checkOutput("burst_full", full, 1);
    checkOutput("burst_level", level, 16);
    checkOutput("burst_ovf", ovf_count, 0);
    checkOutput("burst_one_write", writes_seen, w + 1);
    checkOutput("burst_tx_held", uart_bus.tx_value, 8'h00);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(8'hEE, 1'b0);
    end
    checkOutput("ovf_saturated", ovf_count, 8'hFF);
    checkOutput("ovf_level", level, 16);
    checkOutput("ovf_full", full, 1);

    // Push in the same cycle as the pop of a full FIFO
    pulseDone();
    applyStimulus(8'h77, 1'b1);
    checkOutput("samecycle_level", level, 16);
    checkOutput("samecycle_full", full, 1);
    checkOutput("samecycle_write", uart_bus.tx_value_write, 1);
    checkOutput("samecycle_tx", uart_bus.tx_value, 8'h01);
    checkOutput("samecycle_ovf", ovf_count, 8'hFF);

    drainAll();
    checkOutput("drain_last", last_value, 8'h77);
    checkOutput("drain_level", level, 0);
    checkOutput("drain_empty", empty, 1);

    // Carriage return handling
    $display("[TB] carriage return");
    w = writes_seen;
    applyStimulus(8'h0D, 1'b1);
    applyStimulus(8'h42, 1'b1);
    waitWrites(w + 1);
    drainAll();
    checkOutput("crlf_write_count", writes_seen, w + CRLF_WRITES);
    checkOutput("crlf_last", last_value, 8'h42);

    // Pointer wrap-around from a clean reset
    $display("[TB] wrap-around");
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    tick();
    exp_q.delete();
    checkOutput("wrap_ovf_reset", ovf_count, 0);
    w0 = writes_seen;
    for (int i = 0; i < 40; i++) begin
      w = writes_seen;
      applyStimulus(8'(8'h80 + i), 1'b1);
      waitWrites(w + 1);
      pulseDone();
      tick();
    end
    checkOutput("wrap_write_count", writes_seen, w0 + 40);
    checkOutput("wrap_queue_empty", exp_q.size(), 0);
    checkOutput("wrap_ovf", ovf_count, 0);
    checkOutput("wrap_level", level, 0);
    checkOutput("wrap_last", last_value, 8'hA7);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
